cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_arb_pkg.sv | 18 +
 rtl/cache_arb_pick.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration between contending misses.
package cache_arb_pkg;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_BYTES  = 2;
    localparam logic [2:0]  LAST_WORD   = 3'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} arb_state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_FILL_I, GNT_FILL_D, GNT_WRITE} grant_e;

    // Base has a zero low nibble, so OR-ing the word offset can never carry out of it.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] idx);
        return base | {12'h000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational grant selector: I miss, D miss, then D store.
// With ARB_ROUND_ROBIN_EN, contending misses alternate using the last contested winner.
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic   i_miss,
    input  logic   d_miss,
    input  logic   d_wr,
    input  owner_e last_grant,
    output grant_e gnt,
    output owner_e last_grant_next
);

    always_comb begin
        gnt             = GNT_NONE;
        last_grant_next = last_grant;
        if (i_miss && d_miss) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt = (last_grant == OWN_D) ? GNT_FILL_I : GNT_FILL_D;
`else
            gnt = GNT_FILL_I;
`endif
            // Only a contested decision moves the round-robin pointer.
            last_grant_next = (gnt == GNT_FILL_I) ? OWN_I : OWN_D;
        end else if (i_miss) begin
            gnt = GNT_FILL_I;
        end else if (d_miss) begin
            gnt = GNT_FILL_D;
        end else if (d_wr) begin
            gnt = GNT_WRITE;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache block fills, D-cache block fills and D-side stores.
// ARB_ROUND_ROBIN_EN enables round-robin between simultaneous I and D misses.
module cache_mem_arbiter
    import cache_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        fill_we_i,
    output logic        fill_we_d,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        fill_done,
    output logic        i_stall,
    output logic        d_stall
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_q, last_d, last_next;
    logic [15:0] base_q, base_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic        issue_done_q, issue_done_d;
    grant_e      gnt;

    cache_arb_pick u_pick (
        .i_miss          (i_miss),
        .d_miss          (d_miss),
        .d_wr            (d_wr),
        .last_grant      (last_q),
        .gnt             (gnt),
        .last_grant_next (last_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_q       <= OWN_D;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            rx_cnt_q     <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            issue_done_q <= issue_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                unique case (gnt)
                    GNT_FILL_I, GNT_FILL_D: state_d = FILL;
                    GNT_WRITE:              state_d = WRITE;
                    default:                state_d = IDLE;
                endcase
            end
            FILL:    if (mem_valid && rx_cnt_q == LAST_WORD) state_d = DONE;
            WRITE:   state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_d       = last_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        issue_done_d = issue_done_q;
        if (state_q == IDLE) begin
            last_d = last_next;
            if (gnt == GNT_FILL_I || gnt == GNT_FILL_D) begin
                owner_d      = (gnt == GNT_FILL_I) ? OWN_I : OWN_D;
                base_d       = ((gnt == GNT_FILL_I) ? i_addr : d_addr) & 16'hFFF0;
                issue_cnt_d  = '0;
                rx_cnt_d     = '0;
                issue_done_d = 1'b0;
            end
        end else if (state_q == FILL) begin
            // Counters saturate at 7; a separate flag marks the eighth read as issued.
            if (!issue_done_q) begin
                if (issue_cnt_q == LAST_WORD) issue_done_d = 1'b1;
                else                          issue_cnt_d  = issue_cnt_q + 3'd1;
            end
            if (mem_valid && rx_cnt_q != LAST_WORD) rx_cnt_d = rx_cnt_q + 3'd1;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we_i = 1'b0;
        fill_we_d = 1'b0;
        fill_addr = '0;
        fill_data = '0;
        fill_done = 1'b0;
        i_stall   = 1'b0;
        d_stall   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                FILL: begin
                    if (!issue_done_q) begin
                        mem_en   = 1'b1;
                        mem_addr = word_addr(base_q, issue_cnt_q);
                    end
                    if (mem_valid) begin
                        fill_we_i = (owner_q == OWN_I);
                        fill_we_d = (owner_q == OWN_D);
                        fill_addr = word_addr(base_q, rx_cnt_q);
                    end
                end
                WRITE: begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end
                DONE:    fill_done = 1'b1;
                default: ;
            endcase
            fill_data = mem_rdata;
            i_stall   = i_miss && !(state_q == DONE && owner_q == OWN_I);
            d_stall   = (d_miss || d_wr) &&
                        !((state_q == DONE && owner_q == OWN_D) || state_q == WRITE);
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized request mixes,
// checked against a transaction-level model of grant order and block contents.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        mem_en, mem_wr, fill_we_i, fill_we_d, fill_done, i_stall, d_stall;
    logic [15:0] mem_addr, mem_wdata, fill_addr, fill_data;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_miss    (i_miss),
        .i_addr    (i_addr),
        .d_miss    (d_miss),
        .d_addr    (d_addr),
        .d_wr      (d_wr),
        .d_wdata   (d_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .fill_we_i (fill_we_i),
        .fill_we_d (fill_we_d),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .fill_done (fill_done),
        .i_stall   (i_stall),
        .d_stall   (d_stall)
    );

    // Memory with 4-cycle read latency: a read issued in cycle c returns data in cycle c+4.
    int unsigned cyc = 0;
    bit          pv[3];
    logic [15:0] pa[3];
    always @(posedge clk) begin
        bit          v_now;
        logic [15:0] a_now;
        v_now = mem_en && !mem_wr;
        a_now = mem_addr;
        cyc++;
        #1;
        mem_valid = pv[2];
        mem_rdata = pv[2] ? (pa[2] ^ 16'hA5A5) : 16'h0000;
        pv[2] = pv[1]; pa[2] = pa[1];
        pv[1] = pv[0]; pa[1] = pa[0];
        pv[0] = v_now; pa[0] = a_now;
    end

    typedef struct {
        int unsigned cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic        side;
    } ev_t;

    ev_t         rd_log[$], fw_log[$], wr_log[$], done_log[$];
    int unsigned i_served, d_served, i_served_cyc, d_served_cyc, both_we;
    int unsigned n_checks = 0, n_errors = 0;
    bit          model_last_d = 1'b1;  // most recent contested winner was D

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        ev_t e;
        @(negedge clk);
        e.cyc = cyc; e.side = 1'b0; e.addr = mem_addr; e.data = mem_wdata;
        if (mem_en && !mem_wr) rd_log.push_back(e);
        if (mem_en && mem_wr) begin
            e.side = d_stall;
            wr_log.push_back(e);
        end
        if (fill_we_i || fill_we_d) begin
            e.addr = fill_addr; e.data = fill_data; e.side = fill_we_d;
            fw_log.push_back(e);
            if (fill_we_i && fill_we_d) both_we++;
        end
        if (fill_done) done_log.push_back(e);
        if (i_miss && !i_stall) begin i_served++; i_served_cyc = cyc; end
        if ((d_miss || d_wr) && !d_stall) begin d_served++; d_served_cyc = cyc; end
    endtask

    task automatic clear_logs();
        rd_log.delete(); fw_log.delete(); wr_log.delete(); done_log.delete();
        i_served = 0; d_served = 0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".mem_en"},    mem_en,    0);
        check_eq({tag, ".mem_wr"},    mem_wr,    0);
        check_eq({tag, ".mem_addr"},  mem_addr,  0);
        check_eq({tag, ".mem_wdata"}, mem_wdata, 0);
        check_eq({tag, ".fill_we"},   {fill_we_i, fill_we_d}, 0);
        check_eq({tag, ".fill_addr"}, fill_addr, 0);
        check_eq({tag, ".fill_done"}, fill_done, 0);
        check_eq({tag, ".stalls"},    {i_stall, d_stall}, 0);
    endtask

    // Drives one request mix, waits until every requester is served, then checks the
    // observed reads, fills, stores and stall releases against the model's grant order.
    task automatic run_txn(input bit ri, input bit rdm, input bit rdw, input logic [15:0] ia,
                           input logic [15:0] da, input logic [15:0] dd, input int drop_after,
                           input string tag);
        logic [15:0] exp_base[$];
        bit          exp_side[$];
        bit          first_d;
        int          n;
        if (ri && rdm) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_d = !model_last_d;
`else
            first_d = 1'b0;
`endif
            model_last_d = first_d;
            exp_side.push_back(first_d);
            exp_side.push_back(!first_d);
        end else begin
            if (ri)  exp_side.push_back(1'b0);
            if (rdm) exp_side.push_back(1'b1);
        end
        foreach (exp_side[k]) exp_base.push_back((exp_side[k] ? da : ia) & 16'hFFF0);

        clear_logs();
        i_addr = ia; d_addr = da; d_wdata = dd;
        i_miss = ri; d_miss = rdm; d_wr = rdw;
        n = 0;
        while ((i_miss || d_miss || d_wr) && n < 300) begin
            step();
            n++;
            if (i_miss && !i_stall) i_miss = 1'b0;
            if ((d_miss || d_wr) && !d_stall) begin d_miss = 1'b0; d_wr = 1'b0; end
            if (drop_after > 0 && i_miss && rd_log.size() >= drop_after) i_miss = 1'b0;
        end
        check_eq({tag, ".served_in_budget"}, {i_miss, d_miss, d_wr}, 0);
        i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
        repeat (14) step();

        check_eq({tag, ".n_reads"}, rd_log.size(), 8 * exp_side.size());
        check_eq({tag, ".n_fills"}, fw_log.size(), 8 * exp_side.size());
        check_eq({tag, ".n_done"},  done_log.size(), exp_side.size());
        check_eq({tag, ".n_writes"}, wr_log.size(), rdw);
        check_eq({tag, ".i_served"}, i_served, (ri && drop_after == 0) ? 1 : 0);
        check_eq({tag, ".d_served"}, d_served, (rdm || rdw) ? 1 : 0);
        for (int k = 0; k < 8 * exp_side.size(); k++) begin
            logic [15:0] ea;
            ea = exp_base[k / 8] | 16'((k % 8) * 2);
            if (k < rd_log.size()) check_eq({tag, ".rd_addr"}, rd_log[k].addr, ea);
            if (k < fw_log.size()) begin
                check_eq({tag, ".fill_addr"}, fw_log[k].addr, ea);
                check_eq({tag, ".fill_data"}, fw_log[k].data, ea ^ 16'hA5A5);
                check_eq({tag, ".fill_side"}, fw_log[k].side, exp_side[k / 8]);
            end
        end
        if (rdw && wr_log.size() > 0) begin
            check_eq({tag, ".wr_addr"},  wr_log[0].addr, da);
            check_eq({tag, ".wr_data"},  wr_log[0].data, dd);
            check_eq({tag, ".wr_stall"}, wr_log[0].side, 0);
            check_eq({tag, ".wr_release_cyc"}, d_served_cyc, wr_log[0].cyc);
        end
    endtask

    initial begin
        int unsigned e;
        int          n;

        repeat (3) step();
        check_quiet("in_reset");
        rst = 1'b0;
        step();
        check_quiet("after_reset");

        // Single I miss: timing of issue, completion and stall release.
        run_txn(1, 0, 0, 16'h1236, 16'h0000, 16'h0000, 0, "imiss");
        if (rd_log.size() >= 8 && done_log.size() >= 1) begin
            e = rd_log[0].cyc;
            for (int k = 0; k < 8; k++) check_eq("imiss.rd_cyc", rd_log[k].cyc - e, k);
            check_eq("imiss.done_cyc", done_log[0].cyc - e, 12);
            check_eq("imiss.istall_low_cyc", i_served_cyc - e, 12);
            check_eq("imiss.first_addr", rd_log[0].addr, 16'h1230);
        end else check_eq("imiss.logged", rd_log.size(), 8);

        // Simultaneous misses, twice: order depends on the arbitration mode.
        for (int r = 0; r < 2; r++) begin
            run_txn(1, 1, 0, 16'h4010, 16'h8004, 16'h0000, 0, "contend");
`ifdef ARB_ROUND_ROBIN_EN
            if (fw_log.size() > 0) check_eq("contend.first_side", fw_log[0].side, r);
`else
            if (fw_log.size() > 0) check_eq("contend.first_side", fw_log[0].side, 0);
`endif
            if (done_log.size() == 2) begin
                check_eq("contend.d_release_cyc", d_served_cyc,
                         done_log[fw_log[0].side ? 0 : 1].cyc);
            end
        end

        run_txn(0, 0, 1, 16'h0000, 16'h0040, 16'hBEEF, 0, "store");
        run_txn(1, 0, 0, 16'h3456, 16'h0000, 16'h0000, 2, "drop");

        // Reset in the middle of a fill, right after word 3 lands.
        clear_logs();
        i_addr = 16'h2000; i_miss = 1'b1;
        n = 0;
        while (fw_log.size() < 4 && n < 50) begin step(); n++; end
        check_eq("rstfill.reached_word3", fw_log.size(), 4);
        rst = 1'b1; i_miss = 1'b0;
        step();
        rst = 1'b0;
        model_last_d = 1'b1;
        step();
        check_quiet("rstfill.next");
        clear_logs();
        repeat (10) step();
        check_eq("rstfill.stale_fill_we", fw_log.size(), 0);
        check_eq("rstfill.stale_done", done_log.size(), 0);
        check_eq("rstfill.stale_reads", rd_log.size(), 0);

        for (int t = 0; t < 20; t++) begin
            bit ri, rdm, rdw;
            int dk;
            ri = 1'($urandom % 2);
            dk = int'($urandom % 3);
            rdm = (dk == 1);
            rdw = (dk == 2);
            if (!ri && dk == 0) ri = 1'b1;
            run_txn(ri, rdm, rdw, 16'($urandom), 16'($urandom), 16'($urandom), 0, "rand");
        end
        check_eq("never_both_fill_we", both_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
